wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master Wishbone (pipelined, classic-compatible) arbiter that shares one peripheral bus segment, e.g. the GPIO/UART register slaves, between the CPU data port and a second master such as a DMA or debug port. Grant is round-robin at bus-cycle granularity: a master keeps the bus for as long as it holds cyc. A per-grant watchdog terminates cycles that a slave never acks and returns err to the owning master.

## Interface
- TIMEOUT, 255: cycles without ack, while the owner has stb or an outstanding request, before the cycle is aborted (1..65535).
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mN_wb_cyc_i, mN_wb_stb_i, mN_wb_we_i  in  1 each  master N (N=0,1) cycle, strobe, write.
- mN_wb_addr_i, mN_wb_data_i  in  32 each  master N address and write data.
- mN_wb_sel_i  in  4  master N byte lanes.
- mN_wb_ack_o, mN_wb_err_o  out  1 each  master N ack and timeout error.
- mN_wb_stall_o  out  1  master N stall.
- mN_wb_data_o  out  32  master N read data.
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each  to shared slave bus.
- s_wb_addr_o, s_wb_data_o  out  32 each.
- s_wb_sel_o  out  4.
- s_wb_ack_i, s_wb_stall_i  in  1 each  from slave bus.
- s_wb_data_i  in  32  from slave bus.

## Operation
- States: IDLE, GNT0, GNT1, ABORT. Registers: state, last (last granted master), timeout counter.
- IDLE: a single requester (cyc_i=1) is granted. On simultaneous requests, the master != last wins. Reset value of last is 1, so m0 wins first.
- GNTn: hold while mn_wb_cyc_i=1. When cyc drops, go to IDLE and set last=n. The other master may be granted from IDLE on the next edge. There is no direct GNT0->GNT1 hop.
- Slave bus mux: granted master's cyc/stb/we/addr/data/sel go to s_wb_*_o. In IDLE and ABORT, every s_wb_*_o is 0.
- Owner response: mn_wb_ack_o = s_wb_ack_i, mn_wb_data_o = s_wb_data_i, mn_wb_stall_o = s_wb_stall_i.
- Non-owner response: ack=0, err=0, data=0, stall=1.
- Outstanding count: 0..3 requests, incremented on stb&&!stall, decremented on ack. Saturation is a spec violation by the master.
- Watchdog: counter clears on grant and on every s_wb_ack_i. It increments each GNTn cycle where stb_i=1 or outstanding>0. On reaching TIMEOUT:
  - pulse mn_wb_err_o for 1 cycle;
  - enter ABORT;
  - clear outstanding.
- ABORT: s_wb_cyc_o=0. Stay until the aborted master drops cyc, then go to IDLE with last=aborted master.
- A slave ack arriving in IDLE or ABORT is dropped and is not routed to any master.

## Timing
- Grant latency: 1 clock from cyc_i rising in IDLE to s_wb_cyc_o high. Requester sees stall=1 in the request cycle.
- Data path to and from the granted master is combinational (zero added latency). The slave's own latency is preserved. Pipelined back-to-back stb is supported.
- Release: cyc drop at edge k gives IDLE at k+1; a waiting master is granted at k+2.
- Reset (async, any time, including mid-cycle): state=IDLE, last=1, counters=0. All s_wb_* outputs 0; mN ack/err/data 0; mN stall 1. No partial cycle resumes after reset.
- err is a single-cycle pulse, and never coincides with ack in the same cycle for the same master.

## Structure
- Shared package/header: state encodings (IDLE=0, GNT0=1, GNT1=2, ABORT=3) and the outstanding-counter width.
- Natural sub-module: wb_arb_rr2, the 2-way round-robin grant picker (inputs req[1:0], last; output winner). Mux, watchdog and FSM stay in the top.

## Test plan
- m0 single write 0x0000_00FF to addr 0x10, slave acks 1 cycle after stb: s_wb_cyc_o high 1 cycle after m0 cyc; m0 ack in the same cycle as s_wb_ack_i; m1 stall=1 throughout.
- m0 and m1 raise cyc in the same cycle after reset: m0 granted first. m0 releases; m1 granted 2 cycles after m0 cyc drop. Next tie goes to m0.
- m1 holds cyc with 4 pipelined reads, slave stalls 1 of every 2 cycles: m1 stall mirrors s_wb_stall_i; 4 acks with correct data; m0 request waits until m1 cyc drops.
- Slave never acks, TIMEOUT=8: m0 err pulses exactly once, 8 counting cycles after grant; s_wb_cyc_o low next cycle; ABORT held until m0 cyc=0; m1 then grantable.
- resetn pulsed low mid-transfer with m1 granted: outputs go to reset values immediately; after release, m0 and m1 tie goes to m0.
- Stray s_wb_ack_i in IDLE: neither master sees ack; state stays IDLE.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encodings and
// the width of the per-grant outstanding-request counter.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_e;

  localparam int unsigned      OUTS_W   = 2;
  localparam logic [OUTS_W-1:0] OUTS_MAX = 2'd3;
  localparam logic [OUTS_W-1:0] OUTS_ZERO = 2'd0;

endpackage

// File: rtl/wb_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that was not granted last.
module wb_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  // Winner select from the request vector and last owner
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master pipelined Wishbone arbiter with bus-cycle round-robin grant and
// a per-grant no-ack watchdog that aborts the cycle and returns err.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [31:0] m0_wb_addr_i,
  input  logic [31:0] m0_wb_data_i,
  input  logic [3:0]  m0_wb_sel_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  output logic        m0_wb_stall_o,
  output logic [31:0] m0_wb_data_o,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [31:0] m1_wb_addr_i,
  input  logic [31:0] m1_wb_data_i,
  input  logic [3:0]  m1_wb_sel_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic        m1_wb_stall_o,
  output logic [31:0] m1_wb_data_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [31:0] s_wb_addr_o,
  output logic [31:0] s_wb_data_o,
  output logic [3:0]  s_wb_sel_o,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i,
  input  logic [31:0] s_wb_data_i
);

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  arb_state_e        state_r, state_nxt_s;
  logic              last_r, last_nxt_s;
  logic [15:0]       wdog_r, wdog_nxt_s;
  logic [OUTS_W-1:0] outs_r, outs_nxt_s;
  logic              winner_s, granted_s, own_sel_s, own_cyc_s, own_stb_s;
  logic              counting_s, timeout_s, inc_s;

  wb_arb_rr2 u_rr2 (
    .req    ({m1_wb_cyc_i, m0_wb_cyc_i}),
    .last   (last_r),
    .winner (winner_s)
  );

  assign granted_s  = (state_r == ST_GNT0) || (state_r == ST_GNT1);
  assign own_sel_s  = (state_r == ST_GNT1);
  assign own_cyc_s  = own_sel_s ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign own_stb_s  = own_sel_s ? m1_wb_stb_i : m0_wb_stb_i;
  assign inc_s      = own_stb_s && !s_wb_stall_i;
  assign counting_s = own_stb_s || (outs_r != OUTS_ZERO);
  // An ack in the final counting cycle rescues the transfer, so err never meets ack
  assign timeout_s  = granted_s && own_cyc_s && !s_wb_ack_i && counting_s &&
                      (wdog_r >= WDOG_LAST);

  // Slave-side request mux; bus is fully quiet unless a master owns it
  always_comb begin
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_addr_o = 32'h0000_0000;
    s_wb_data_o = 32'h0000_0000;
    s_wb_sel_o  = 4'h0;
    if (granted_s) begin
      if (own_sel_s) begin
        s_wb_cyc_o  = m1_wb_cyc_i;
        s_wb_stb_o  = m1_wb_stb_i;
        s_wb_we_o   = m1_wb_we_i;
        s_wb_addr_o = m1_wb_addr_i;
        s_wb_data_o = m1_wb_data_i;
        s_wb_sel_o  = m1_wb_sel_i;
      end else begin
        s_wb_cyc_o  = m0_wb_cyc_i;
        s_wb_stb_o  = m0_wb_stb_i;
        s_wb_we_o   = m0_wb_we_i;
        s_wb_addr_o = m0_wb_addr_i;
        s_wb_data_o = m0_wb_data_i;
        s_wb_sel_o  = m0_wb_sel_i;
      end
    end else begin
      s_wb_cyc_o = 1'b0;
    end
  end

  // Master-side response routing; acks outside a grant are dropped
  always_comb begin
    m0_wb_ack_o   = 1'b0;
    m0_wb_err_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m0_wb_data_o  = 32'h0000_0000;
    m1_wb_ack_o   = 1'b0;
    m1_wb_err_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    m1_wb_data_o  = 32'h0000_0000;
    case (state_r)
      ST_GNT0: begin
        m0_wb_ack_o   = s_wb_ack_i;
        m0_wb_err_o   = timeout_s;
        m0_wb_stall_o = s_wb_stall_i;
        m0_wb_data_o  = s_wb_data_i;
      end
      ST_GNT1: begin
        m1_wb_ack_o   = s_wb_ack_i;
        m1_wb_err_o   = timeout_s;
        m1_wb_stall_o = s_wb_stall_i;
        m1_wb_data_o  = s_wb_data_i;
      end
      default: begin
        m0_wb_stall_o = 1'b1;
      end
    endcase
  end

  // Next-state and last-owner logic; ABORT reuses last to track the aborted master
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_wb_cyc_i || m1_wb_cyc_i) begin
          state_nxt_s = winner_s ? ST_GNT1 : ST_GNT0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!own_cyc_s) begin
          state_nxt_s = ST_IDLE;
          last_nxt_s  = own_sel_s;
        end else if (timeout_s) begin
          state_nxt_s = ST_ABORT;
          last_nxt_s  = own_sel_s;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_ABORT: begin
        if (!(last_r ? m1_wb_cyc_i : m0_wb_cyc_i)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ABORT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Watchdog and outstanding counters live only within an active grant
  always_comb begin
    wdog_nxt_s = 16'd0;
    outs_nxt_s = OUTS_ZERO;
    if (granted_s && own_cyc_s && !timeout_s) begin
      if (s_wb_ack_i) begin
        wdog_nxt_s = 16'd0;
      end else if (counting_s) begin
        wdog_nxt_s = wdog_r + 16'd1;
      end else begin
        wdog_nxt_s = wdog_r;
      end
      if (inc_s && !s_wb_ack_i && (outs_r != OUTS_MAX)) begin
        outs_nxt_s = outs_r + 2'd1;
      end else if (!inc_s && s_wb_ack_i && (outs_r != OUTS_ZERO)) begin
        outs_nxt_s = outs_r - 2'd1;
      end else begin
        outs_nxt_s = outs_r;
      end
    end else begin
      wdog_nxt_s = 16'd0;
    end
  end

  // State, last-owner and counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
      wdog_r  <= 16'd0;
      outs_r  <= OUTS_ZERO;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      wdog_r  <= wdog_nxt_s;
      outs_r  <= outs_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a reactive slave model feeds a response
// scoreboard that a negedge monitor drains whenever a master sees ack or err.
module tb_wb_arbiter;

  typedef struct packed {
    logic        m;
    logic        is_err;
    logic [31:0] data;
  } sb_item_t;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
  logic [3:0]  m0_sel = 4'h0;
  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
  logic [3:0]  m1_sel = 4'h0;
  logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_sel;
  logic        slv_ack = 1'b0, slv_stall = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_noack = 1'b0, slv_stall_mode = 1'b0;
  logic        owner_exp = 1'b0, last_acc = 1'b0;
  sb_item_t    sb_q[$];
  int          tests = 0;
  int          fails = 0;

  wb_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_addr_i(m0_addr), .m0_wb_data_i(m0_wdata), .m0_wb_sel_i(m0_sel),
    .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err), .m0_wb_stall_o(m0_stall),
    .m0_wb_data_o(m0_rdata),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_addr_i(m1_addr), .m1_wb_data_i(m1_wdata), .m1_wb_sel_i(m1_sel),
    .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err), .m1_wb_stall_o(m1_stall),
    .m1_wb_data_o(m1_rdata),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_addr_o(s_addr), .s_wb_data_o(s_wdata), .s_wb_sel_o(s_sel),
    .s_wb_ack_i(slv_ack), .s_wb_stall_i(slv_stall), .s_wb_data_i(slv_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock: slave samples an accepted strobe, then answers one cycle later
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    logic [31:0] ea;
    #1;
    acc = s_cyc && s_stb && !slv_stall;
    a   = s_addr;
    ea  = owner_exp ? m1_addr : m0_addr;
    if (acc && !slv_noack) sb_q.push_back('{owner_exp, 1'b0, ea ^ MAGIC});
    last_acc = acc;
    @(posedge clk);
    #1;
    slv_ack   = acc && !slv_noack;
    slv_rdata = acc ? (a ^ MAGIC) : 32'h0;
    slv_stall = slv_stall_mode ? ~slv_stall : 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    slv_ack = 1'b0; slv_stall = 1'b0; slv_rdata = 32'h0;
    slv_stall_mode = 1'b0; slv_noack = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic mon_port(input logic m, input logic ack, input logic err, input logic [31:0] d);
    sb_item_t it;
    if (ack || err) begin
      tests++;
      if (ack && err) begin
        fails++;
        $display("FAIL ack_err_overlap m%0d: got ack=1 err=1, want one of them", m);
      end else if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp m%0d: got ack=%0b err=%0b data=%h, want none", m, ack, err, d);
      end else begin
        it = sb_q.pop_front();
        if (it.m !== m || it.is_err !== err || (ack && d !== it.data)) begin
          fails++;
          $display("FAIL sb_resp: got m%0d err=%0b data=%h, want m%0d err=%0b data=%h",
                   m, err, d, it.m, it.is_err, it.data);
        end
      end
    end
  endtask

  // Response monitor, decoupled from the stimulus thread
  always @(negedge clk) begin
    if (resetn) begin
      mon_port(1'b0, m0_ack, m0_err, m0_rdata);
      mon_port(1'b1, m1_ack, m1_err, m1_rdata);
    end
  end

  initial begin
    int idx;
    int n;
    logic got;
    #1 resetn = 1'b0;
    #1;
    chk1("rst_s_cyc", s_cyc, 1'b0);
    chk32("rst_s_addr", s_addr, 32'h0);
    chk1("rst_m0_stall", m0_stall, 1'b1);
    chk1("rst_m1_stall", m1_stall, 1'b1);
    chk1("rst_m0_ack", m0_ack, 1'b0);
    do_reset();

    // single write from m0
    owner_exp = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_addr = 32'h10;
    m0_wdata = 32'h0000_00FF; m0_sel = 4'hF;
    #1;
    chk1("w_req_stall", m0_stall, 1'b1);
    chk1("w_idle_s_cyc", s_cyc, 1'b0);
    tick();
    #1;
    chk1("w_s_cyc", s_cyc, 1'b1);
    chk1("w_s_we", s_we, 1'b1);
    chk32("w_s_addr", s_addr, 32'h10);
    chk32("w_s_data", s_wdata, 32'h0000_00FF);
    chk1("w_m1_stall", m1_stall, 1'b1);
    tick();
    m0_stb = 1'b0;
    #1;
    chk1("w_m0_ack_same_cycle", m0_ack, 1'b1);
    chk1("w_m1_stall2", m1_stall, 1'b1);
    chk1("w_m1_ack", m1_ack, 1'b0);
    tick();
    m0_cyc = 1'b0; m0_we = 1'b0;
    tick();
    #1;
    chk1("w_release", s_cyc, 1'b0);

    // simultaneous requests after reset
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    #1;
    chk1("tie_m0_stall", m0_stall, 1'b0);
    chk1("tie_m1_stall", m1_stall, 1'b1);
    tick();
    m0_cyc = 1'b0;
    tick();
    #1;
    chk1("rel_idle_s_cyc", s_cyc, 1'b0);
    chk1("rel_idle_m1_stall", m1_stall, 1'b1);
    tick();
    #1;
    chk1("rel_m1_granted", m1_stall, 1'b0);
    chk1("rel_m1_s_cyc", s_cyc, 1'b1);
    m1_cyc = 1'b0;
    tick();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    #1;
    chk1("tie2_m0_stall", m0_stall, 1'b0);
    chk1("tie2_m1_stall", m1_stall, 1'b1);
    m1_cyc = 1'b0;
    tick();
    m0_cyc = 1'b0;
    tick();

    // m1 pipelined reads against a slave that stalls every other cycle
    owner_exp = 1'b1; slv_stall_mode = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h100;
    tick();
    m0_cyc = 1'b1;
    idx = 0;
    for (int c = 0; c < 40 && !(idx == 4 && sb_q.size() == 0); c++) begin
      if (idx < 4) begin
        m1_stb = 1'b1; m1_addr = 32'h100 + 32'(idx * 4);
      end else begin
        m1_stb = 1'b0;
      end
      #1;
      chk1("pipe_m1_stall_mirror", m1_stall, slv_stall);
      chk1("pipe_m0_waits", m0_stall, 1'b1);
      tick();
      if (last_acc) idx++;
    end
    chk1("pipe_done", (idx == 4) && (sb_q.size() == 0), 1'b1);
    m1_cyc = 1'b0; m1_stb = 1'b0; slv_stall_mode = 1'b0;
    #1;
    chk1("pipe_drop_s_cyc", s_cyc, 1'b0);
    tick();
    #1;
    chk1("pipe_m0_idle_stall", m0_stall, 1'b1);
    tick();
    #1;
    chk1("pipe_m0_granted", m0_stall, 1'b0);
    m0_cyc = 1'b0;
    tick();

    // watchdog: slave never acks
    owner_exp = 1'b0; slv_noack = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h20;
    sb_q.push_back('{1'b0, 1'b1, 32'h0});
    tick();
    n = 0; got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) m0_stb = 1'b0;
      #1;
      n++;
      if (m0_err) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk1("wd_err_seen", got, 1'b1);
    chk32("wd_err_cycle", 32'(n), 32'd8);
    tick();
    #1;
    chk1("wd_err_single", m0_err, 1'b0);
    chk1("wd_abort_s_cyc", s_cyc, 1'b0);
    m1_cyc = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      chk1("wd_abort_hold", s_cyc, 1'b0);
      chk1("wd_abort_m1_stall", m1_stall, 1'b1);
      chk1("wd_abort_no_err", m0_err, 1'b0);
    end
    m0_cyc = 1'b0; slv_noack = 1'b0;
    tick();
    #1;
    chk1("wd_idle_m1_stall", m1_stall, 1'b1);
    tick();
    #1;
    chk1("wd_m1_granted", m1_stall, 1'b0);
    chk1("wd_m1_s_cyc", s_cyc, 1'b1);

    // asynchronous reset in the middle of an m1 transfer
    owner_exp = 1'b1;
    m1_stb = 1'b1; m1_addr = 32'h30; m0_cyc = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk1("ar_s_cyc", s_cyc, 1'b0);
    chk1("ar_s_stb", s_stb, 1'b0);
    chk32("ar_s_addr", s_addr, 32'h0);
    chk1("ar_m1_stall", m1_stall, 1'b1);
    chk1("ar_m0_stall", m0_stall, 1'b1);
    chk32("ar_m1_data", m1_rdata, 32'h0);
    slv_ack = 1'b0; m1_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    owner_exp = 1'b0;
    tick();
    #1;
    chk1("ar_tie_m0", m0_stall, 1'b0);
    chk1("ar_tie_m1", m1_stall, 1'b1);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    tick();

    // stray slave ack while idle
    slv_ack = 1'b1; slv_rdata = 32'hDEAD_BEEF;
    #1;
    chk1("stray_m0_ack", m0_ack, 1'b0);
    chk1("stray_m1_ack", m1_ack, 1'b0);
    chk32("stray_m0_data", m0_rdata, 32'h0);
    tick();
    m0_cyc = 1'b1;
    tick();
    #1;
    chk1("stray_still_idle", m0_stall, 1'b0);
    m0_cyc = 1'b0;
    tick();
    tick();

    chk32("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
